slave_serial_port: RTL and testbench

Responder-side end of the bit-serial bus protocol that the master ports drive.
- Deserialises address and write data arriving LSB-first from the interconnect, performs a single-beat access to a local synchronous memory, and serialises read data back under a valid/ready handshake.
- Asserts split_en during long read latencies.
- Sits between Bus_interconnect slave channels (s*_*) and a new slave's storage array.

---
 rtl/bus_pkg.sv | 28 ++
 rtl/serial_shift_reg.sv | 32 +++
 rtl/slave_serial_port.sv | 221 ++++++++++++++++++++++
 tb/tb_slave_serial_port.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the bit-serial bus slave port.
//   state_t            : FSM state encoding (3 bits)
//   *_DEFAULT          : default transaction geometry and split threshold
//   DELAY_W            : width of the slave_delay input
//   cnt_width()        : bit-counter width able to hold max(a,b)
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_WRITE,
    ST_WAIT,
    ST_READ,
    ST_LOAD,
    ST_TX
  } state_t;

  localparam int ADDR_LEN_DEFAULT        = 12;
  localparam int DATA_LEN_DEFAULT        = 8;
  localparam int SPLIT_THRESHOLD_DEFAULT = 8;
  localparam int DELAY_W                 = 6;

  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// LSB-first shift register. A parallel load has priority over a shift; a
// shift moves every bit one place toward bit 0 and enters shift_in at the
// MSB, so after WIDTH shifts the first bit received sits in bit 0.
//   clk, rst   : clock, asynchronous active-low reset (clears q)
//   load       : parallel load of load_data
//   load_data  : parallel load value
//   shift      : shift enable
//   shift_in   : bit entering at the MSB
//   q          : register contents (q[0] is the next bit out)
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic             shift_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= {shift_in, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/slave_serial_port.sv
// Responder end of the bit-serial bus. Deserialises an LSB-first address
// (and write data), performs one access to a local synchronous memory and
// serialises read data back under a valid/ready handshake. split_en is
// raised for the whole read wait when the requested delay is long.
//   clk, rst        : clock, asynchronous active-low reset
//   slave_delay     : read wait cycles, sampled when entering WAIT
//   read_en/write_en: transaction select from the interconnect
//   master_valid    : serial input bits valid this cycle
//   master_ready    : master accepts tx_data this cycle
//   rx_address      : serial address bit, LSB first
//   rx_data         : serial write data bit, LSB first
//   slave_ready     : port accepts serial input bits
//   slave_valid     : tx_data holds a valid read bit
//   tx_data         : serial read data bit, LSB first
//   split_en        : split request during a long read wait
//   mem_addr        : deserialised memory address
//   mem_wdata       : memory write data
//   mem_we, mem_re  : one-cycle write / read strobes
//   mem_rdata       : memory read data, valid the cycle after mem_re
module slave_serial_port
  import bus_pkg::*;
#(
  parameter int ADDR_LEN        = ADDR_LEN_DEFAULT,
  parameter int DATA_LEN        = DATA_LEN_DEFAULT,
  parameter int SPLIT_THRESHOLD = SPLIT_THRESHOLD_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DELAY_W-1:0]  slave_delay,
  input  logic                read_en,
  input  logic                write_en,
  input  logic                master_valid,
  input  logic                master_ready,
  input  logic                rx_address,
  input  logic                rx_data,
  output logic                slave_ready,
  output logic                slave_valid,
  output logic                tx_data,
  output logic                split_en,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic                mem_we,
  output logic                mem_re,
  input  logic [DATA_LEN-1:0] mem_rdata
);

  localparam int CNT_W = cnt_width(ADDR_LEN, DATA_LEN);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_LEN - 1);

  state_t             state, state_nxt;
  logic               is_write, is_write_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [DELAY_W-1:0] delay_cnt, delay_nxt;
  logic               split_q, split_nxt;

  logic addr_shift, wdata_shift, rdata_load, rdata_shift;
  logic [DATA_LEN-1:0] tx_shift;
  logic                unused_tx_bits;

  always_comb begin
    state_nxt    = state;
    is_write_nxt = is_write;
    cnt_nxt      = cnt;
    delay_nxt    = delay_cnt;
    split_nxt    = split_q;
    addr_shift   = 1'b0;
    wdata_shift  = 1'b0;
    rdata_load   = 1'b0;
    rdata_shift  = 1'b0;
    slave_ready  = 1'b0;
    slave_valid  = 1'b0;
    split_en     = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;

    case (state)
      ST_IDLE: begin
        slave_ready = 1'b1;
        // Exactly one select must be high to start; both or neither is ignored.
        if (master_valid && (read_en ^ write_en)) begin
          is_write_nxt = write_en;
          addr_shift   = 1'b1;
          cnt_nxt      = CNT_W'(1);
          state_nxt    = ST_ADDR;
        end
      end

      ST_ADDR: begin
        slave_ready = 1'b1;
        if (!read_en && !write_en) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else if (master_valid) begin
          addr_shift = 1'b1;
          if (cnt == ADDR_LAST) begin
            cnt_nxt = '0;
            if (is_write) begin
              state_nxt = ST_WDATA;
            end else begin
              // The wait length and split decision are frozen here.
              delay_nxt = slave_delay;
              split_nxt = (32'(slave_delay) >= 32'(SPLIT_THRESHOLD));
              state_nxt = ST_WAIT;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end

      ST_WDATA: begin
        slave_ready = 1'b1;
        if (!read_en && !write_en) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else if (master_valid) begin
          wdata_shift = 1'b1;
          if (cnt == DATA_LAST) begin
            cnt_nxt   = '0;
            state_nxt = ST_WRITE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end

      ST_WRITE: begin
        slave_ready = 1'b1;
        mem_we      = 1'b1;
        state_nxt   = ST_IDLE;
      end

      ST_WAIT: begin
        split_en = split_q;
        if (delay_cnt == '0) begin
          state_nxt = ST_READ;
        end else begin
          delay_nxt = delay_cnt - 1'b1;
        end
      end

      ST_READ: begin
        mem_re    = 1'b1;
        state_nxt = ST_LOAD;
      end

      ST_LOAD: begin
        rdata_load = 1'b1;
        state_nxt  = ST_TX;
      end

      ST_TX: begin
        slave_valid = 1'b1;
        if (master_ready) begin
          rdata_shift = 1'b1;
          if (cnt == DATA_LAST) begin
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      is_write  <= 1'b0;
      cnt       <= '0;
      delay_cnt <= '0;
      split_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      is_write  <= is_write_nxt;
      cnt       <= cnt_nxt;
      delay_cnt <= delay_nxt;
      split_q   <= split_nxt;
    end
  end

  serial_shift_reg #(.WIDTH(ADDR_LEN)) u_addr_sr (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .load_data ('0),
    .shift     (addr_shift),
    .shift_in  (rx_address),
    .q         (mem_addr)
  );

  serial_shift_reg #(.WIDTH(DATA_LEN)) u_wdata_sr (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .load_data ('0),
    .shift     (wdata_shift),
    .shift_in  (rx_data),
    .q         (mem_wdata)
  );

  serial_shift_reg #(.WIDTH(DATA_LEN)) u_rdata_sr (
    .clk       (clk),
    .rst       (rst),
    .load      (rdata_load),
    .load_data (mem_rdata),
    .shift     (rdata_shift),
    .shift_in  (1'b0),
    .q         (tx_shift)
  );

  assign tx_data = tx_shift[0];

  // Upper read bits only feed the shift chain; nothing observes them directly.
  assign unused_tx_bits = ^tx_shift[DATA_LEN-1:1];

endmodule

// File: tb/tb_slave_serial_port.sv
// Scoreboard bench for slave_serial_port: stimulus tasks push expected
// memory strobes and read bit streams; a negedge monitor pops and compares.
module tb_slave_serial_port;

  localparam int ADDR_LEN        = 12;
  localparam int DATA_LEN        = 8;
  localparam int SPLIT_THRESHOLD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  slave_delay = '0;
  logic        read_en = 1'b0, write_en = 1'b0;
  logic        master_valid = 1'b0, master_ready = 1'b0;
  logic        rx_address = 1'b0, rx_data = 1'b0;
  logic        slave_ready, slave_valid, tx_data, split_en;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_re;
  logic [7:0]  mem_rdata = '0;

  slave_serial_port #(
    .ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN), .SPLIT_THRESHOLD(SPLIT_THRESHOLD)
  ) dut (
    .clk(clk), .rst(rst), .slave_delay(slave_delay), .read_en(read_en),
    .write_en(write_en), .master_valid(master_valid), .master_ready(master_ready),
    .rx_address(rx_address), .rx_data(rx_data), .slave_ready(slave_ready),
    .slave_valid(slave_valid), .tx_data(tx_data), .split_en(split_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] def_data(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5A;
  endfunction

  // Reference model memory (what the bus should have written) and the
  // environment memory sitting behind the DUT.
  logic [7:0] ref_mem [logic [11:0]];
  logic [7:0] env_mem [logic [11:0]];

  always @(negedge clk) begin
    if (rst && mem_we) env_mem[mem_addr] = mem_wdata;
    if (rst && mem_re) mem_rdata = env_mem.exists(mem_addr) ? env_mem[mem_addr] : def_data(mem_addr);
  end

  typedef struct { logic [11:0] addr; logic [7:0] data; int cyc; } wr_exp_t;
  typedef struct { logic [11:0] addr; logic [7:0] data; int re_cyc; int split_cycles; } rd_exp_t;
  wr_exp_t wq[$];
  rd_exp_t rq[$];

  // Monitor state
  int         writes_done = 0, reads_done = 0;
  bit         tx_active = 0, tx_seen = 0, drop_chk = 0;
  logic [7:0] tx_exp = '0;
  int         tx_cnt = 0, tx_first = 0, split_acc = 0;
  logic       prev_valid = 0, prev_ready = 0, prev_bit = 0;

  always @(negedge clk) begin
    wr_exp_t w;
    rd_exp_t r;
    if (!rst) begin
      prev_valid = 0;
      drop_chk   = 0;
      split_acc  = 0;
    end else begin
      if (split_en) split_acc++;
      if (drop_chk) begin
        check("valid_drop", 32'(slave_valid), 32'(0));
        drop_chk = 0;
      end else if (prev_valid && !prev_ready) begin
        check("tx_hold_valid", 32'(slave_valid), 32'(1));
        check("tx_hold_bit", 32'(tx_data), 32'(prev_bit));
      end
      if (mem_we) begin
        if (wq.size() == 0) check("we_unexpected", 32'(mem_we), 32'(0));
        else begin
          w = wq.pop_front();
          check("we_addr", 32'(mem_addr), 32'(w.addr));
          check("we_data", 32'(mem_wdata), 32'(w.data));
          check("we_cycle", cyc, w.cyc);
          check("we_split", split_acc, 0);
          writes_done++;
        end
        split_acc = 0;
      end
      if (mem_re) begin
        if (rq.size() == 0) check("re_unexpected", 32'(mem_re), 32'(0));
        else begin
          r = rq.pop_front();
          check("re_addr", 32'(mem_addr), 32'(r.addr));
          check("re_cycle", cyc, r.re_cyc);
          check("split_cycles", split_acc, r.split_cycles);
          check("re_ready", 32'(slave_ready), 32'(0));
          tx_active = 1;
          tx_seen   = 0;
          tx_exp    = r.data;
          tx_cnt    = 0;
          tx_first  = r.re_cyc + 2;
        end
        split_acc = 0;
      end
      if (slave_valid) begin
        if (!tx_active) check("valid_unexpected", 32'(slave_valid), 32'(0));
        else begin
          if (!tx_seen) begin
            check("tx_first_cycle", cyc, tx_first);
            tx_seen = 1;
          end
          if (master_ready) begin
            check("tx_bit", 32'(tx_data), 32'(tx_exp[tx_cnt]));
            tx_cnt++;
            if (tx_cnt == DATA_LEN) begin
              tx_active = 0;
              drop_chk  = 1;
              reads_done++;
            end
          end
        end
      end
      prev_valid = slave_valid;
      prev_ready = master_ready;
      prev_bit   = tx_data;
    end
  end

  task automatic idle_cycle();
    @(posedge clk); #1;
    master_valid = 0; read_en = 0; write_en = 0; master_ready = 0;
  endtask

  // Drives address (and data for writes) bits; gap_mode 0: none,
  // 1: three idle cycles after bit 4, 2: random idle cycles.
  task automatic send_bits(input bit is_wr, input logic [11:0] a, input logic [7:0] d,
                           input int gap_mode, output int t0, output int last);
    int n;
    int g;
    n = is_wr ? ADDR_LEN + DATA_LEN : ADDR_LEN;
    t0 = 0;
    last = 0;
    for (int i = 0; i < n; i++) begin
      g = 0;
      if (i > 0) begin
        if (gap_mode == 1 && i == 5) g = 3;
        else if (gap_mode == 2 && $urandom_range(0, 3) == 0) g = int'($urandom_range(1, 3));
      end
      repeat (g) begin
        @(posedge clk); #1;
        master_valid = 0;
        rx_address = 1'($urandom);
        rx_data = 1'($urandom);
      end
      @(posedge clk); #1;
      master_valid = 1;
      read_en = !is_wr;
      write_en = is_wr;
      if (i < ADDR_LEN) begin
        rx_address = a[i];
        rx_data = 1'($urandom);
      end else begin
        rx_address = 1'($urandom);
        rx_data = d[i - ADDR_LEN];
      end
      check("ready_in", 32'(slave_ready), 32'(1));
      if (i == 0) t0 = cyc;
      last = cyc;
    end
  endtask

  task automatic run_write(input logic [11:0] a, input logic [7:0] d, input int gap_mode);
    int t0, last, target;
    send_bits(1, a, d, gap_mode, t0, last);
    wq.push_back('{a, d, last + 1});
    ref_mem[a] = d;
    target = writes_done + 1;
    for (int k = 0; k < 20 && writes_done < target; k++) idle_cycle();
    if (writes_done < target) check("write_timeout", 32'(writes_done), 32'(target));
    idle_cycle();
  endtask

  // ready_mode 0: always ready, 1: alternating, 2: random.
  // rst_at >= 0 pulls reset after that many bits have been accepted.
  task automatic run_read(input logic [11:0] a, input int delay, input int gap_mode,
                          input int ready_mode, input int rst_at);
    int t0, last, target;
    logic [7:0] d;
    slave_delay = 6'(delay);
    send_bits(0, a, 8'h00, gap_mode, t0, last);
    d = ref_mem.exists(a) ? ref_mem[a] : def_data(a);
    rq.push_back('{a, d, last + delay + 2, (delay >= SPLIT_THRESHOLD) ? delay + 1 : 0});
    target = reads_done + 1;
    for (int k = 0; k < 300 && reads_done < target; k++) begin
      @(posedge clk); #1;
      master_valid = 0;
      read_en = 0;
      if (rst_at >= 0 && tx_active && tx_cnt == rst_at) begin
        check("pre_rst_valid", 32'(slave_valid), 32'(1));
        rst = 0;
        #1;
        check("rst_valid", 32'(slave_valid), 32'(0));
        check("rst_ready", 32'(slave_ready), 32'(1));
        check("rst_tx_data", 32'(tx_data), 32'(0));
        check("rst_addr", 32'(mem_addr), 32'(0));
        check("rst_strobes", 32'({mem_we, mem_re, split_en}), 32'(0));
        tx_active = 0;
        rq.delete();
        master_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        return;
      end
      case (ready_mode)
        0: master_ready = 1;
        1: master_ready = 1'(cyc % 2);
        default: master_ready = 1'($urandom);
      endcase
    end
    if (reads_done < target) check("read_timeout", 32'(reads_done), 32'(target));
    idle_cycle();
  endtask

  task automatic abort_txn(input bit is_wr, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1;
      master_valid = 1; read_en = !is_wr; write_en = is_wr;
      rx_address = 1'($urandom); rx_data = 1'($urandom);
    end
    idle_cycle();
    idle_cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] a;
    ref_mem[12'h0F3] = 8'hC5;
    env_mem[12'h0F3] = 8'hC5;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(slave_ready), 32'(1));
    check("reset_valid", 32'(slave_valid), 32'(0));
    check("reset_tx_data", 32'(tx_data), 32'(0));
    check("reset_split", 32'(split_en), 32'(0));
    check("reset_addr", 32'(mem_addr), 32'(0));
    check("reset_wdata", 32'(mem_wdata), 32'(0));
    check("reset_we", 32'(mem_we), 32'(0));
    check("reset_re", 32'(mem_re), 32'(0));
    rst = 1;
    idle_cycle();
    idle_cycle();

    run_write(12'hA5C, 8'h3E, 0);          // plain write
    run_read(12'h0F3, 0, 0, 0, -1);        // zero-delay read of C5
    run_read(12'h7E1, 10, 0, 0, -1);       // long wait with split
    run_read(12'hA5C, 7, 0, 1, -1);        // just below threshold, stalled TX
    run_write(12'h123, 8'hB7, 1);          // address gap
    run_read(12'h123, 8, 0, 2, -1);        // exactly at threshold

    // Both selects high, then both low: neither may start a transaction.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      master_valid = 1; read_en = 1; write_en = 1; rx_address = 1;
    end
    @(posedge clk); #1;
    read_en = 0; write_en = 0;
    run_write(12'h5A1, 8'h96, 0);

    abort_txn(1, 6);                        // abort during address
    abort_txn(1, 15);                       // abort during write data
    abort_txn(0, 9);                        // abort during read address
    run_read(12'h5A1, 1, 0, 0, -1);

    run_read(12'h0F3, 2, 0, 0, 3);          // reset in the middle of TX
    run_read(12'h0F3, 0, 0, 0, -1);

    for (int n = 0; n < 40; n++) begin
      a = 12'h300 + 12'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1)
        run_write(a, 8'($urandom), int'($urandom_range(0, 2)));
      else
        run_read(a, int'($urandom_range(0, 14)), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 2)), -1);
    end

    repeat (5) idle_cycle();
    check("write_queue_empty", 32'(wq.size()), 32'(0));
    check("read_queue_empty", 32'(rq.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
